// File: rtl/alu_op_sequencer.sv
// Sequences requests from decode onto a combinational alu_8 instance, owns the
// architectural {N,Z,V,C} flag register and returns results on a response stream.
// Optional build macro: ALU_SEQ_WIDE_EN enables two-pass (2*WIDTH) ADD..NOT.
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_op,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic               req_use_carry,
    input  logic               req_set_flags,
    input  logic               req_wide,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_y,
    output logic [3:0]         rsp_flags,
    output logic [3:0]         flags,
    input  logic               flag_we,
    input  logic [3:0]         flag_wdata,
    output logic               busy,
    output logic [WIDTH-1:0]   alu_A,
    output logic [WIDTH-1:0]   alu_B,
    output logic [2:0]         alu_OP,
    output logic               alu_C_in,
    output logic               alu_EN,
    output logic               alu_update_flags,
    input  logic [WIDTH-1:0]   alu_Y,
    input  logic               alu_C_out,
    input  logic               alu_Z,
    input  logic               alu_N,
    input  logic               alu_V
);

`ifdef ALU_SEQ_WIDE_EN
    localparam int unsigned OPW = 2 * WIDTH;
`else
    localparam int unsigned OPW = WIDTH;
`endif

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC_LO = 2'd1,
        S_EXEC_HI = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       op_q;
    logic [OPW-1:0]   a_q;
    logic [OPW-1:0]   b_q;
    logic             use_carry_q;
    logic             set_flags_q;

    logic             last_exec_c;
    logic             z_lo_c;
    logic [3:0]       op_flags_c;

`ifdef ALU_SEQ_WIDE_EN
    logic             wide_q;
    logic             c_lo_q;
    logic             z_lo_q;
`else
    logic             unused_wide_inputs;
    assign unused_wide_inputs = ^{req_wide, req_a[2*WIDTH-1:WIDTH], req_b[2*WIDTH-1:WIDTH]};
`endif

    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    // Wide ops AND the zero flags of both passes; narrow ops use the single pass.
`ifdef ALU_SEQ_WIDE_EN
    assign z_lo_c = (state == S_EXEC_HI) ? z_lo_q : 1'b1;
`else
    assign z_lo_c = 1'b1;
`endif
    assign op_flags_c = {alu_N, alu_Z & z_lo_c, alu_V, alu_C_out};

    // Next-state decode and ALU port drive; ALU idles at all-zero outside EXEC states.
    always_comb begin
        state_nxt        = state;
        alu_A            = '0;
        alu_B            = '0;
        alu_OP           = 3'b000;
        alu_C_in         = 1'b0;
        alu_EN           = 1'b0;
        alu_update_flags = 1'b0;
        last_exec_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = S_EXEC_LO;
                end
            end
            S_EXEC_LO: begin
                alu_EN           = 1'b1;
                alu_update_flags = 1'b1;
                alu_A            = a_q[WIDTH-1:0];
                alu_B            = b_q[WIDTH-1:0];
                alu_OP           = op_q;
                alu_C_in         = use_carry_q ? flags[0] : (op_q == OP_SUB);
`ifdef ALU_SEQ_WIDE_EN
                if (wide_q) begin
                    state_nxt = S_EXEC_HI;
                end else begin
                    state_nxt   = S_RESP;
                    last_exec_c = 1'b1;
                end
`else
                state_nxt   = S_RESP;
                last_exec_c = 1'b1;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            S_EXEC_HI: begin
                alu_EN           = 1'b1;
                alu_update_flags = 1'b1;
                alu_A            = a_q[OPW-1:WIDTH];
                alu_B            = b_q[OPW-1:WIDTH];
                alu_OP           = op_q;
                alu_C_in         = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? c_lo_q : 1'b0;
                state_nxt        = S_RESP;
                last_exec_c      = 1'b1;
            end
`endif
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, request latch, result capture and flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            flags     <= '0;
            rsp_y     <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nxt;

            if ((state == S_IDLE) && req_valid) begin
                op_q        <= req_op;
                a_q         <= req_a[OPW-1:0];
                b_q         <= req_b[OPW-1:0];
                use_carry_q <= req_use_carry;
                set_flags_q <= req_set_flags;
`ifdef ALU_SEQ_WIDE_EN
                wide_q      <= req_wide && (req_op <= OP_NOT);
`endif
            end

            if (state == S_EXEC_LO) begin
                rsp_y <= {{WIDTH{1'b0}}, alu_Y};
`ifdef ALU_SEQ_WIDE_EN
                c_lo_q <= alu_C_out;
                z_lo_q <= alu_Z;
`endif
            end
`ifdef ALU_SEQ_WIDE_EN
            if (state == S_EXEC_HI) begin
                rsp_y[2*WIDTH-1:WIDTH] <= alu_Y;
            end
`endif

            if (last_exec_c) begin
                rsp_flags <= op_flags_c;
            end

            // An op commit takes priority over a coincident software write.
            if (last_exec_c && set_flags_q) begin
                flags <= op_flags_c;
            end else if (flag_we) begin
                flags <= flag_wdata;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external alu_8, drives directed and
// random requests, and compares against a plain-arithmetic reference.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_WIDE_EN
    localparam bit WIDE_EN = 1'b1;
`else
    localparam bit WIDE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_use_carry;
    logic        req_set_flags;
    logic        req_wide;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic [3:0]  rsp_flags;
    logic [3:0]  flags;
    logic        flag_we;
    logic [3:0]  flag_wdata;
    logic        busy;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_OP;
    logic        alu_C_in;
    logic        alu_EN;
    logic        alu_update_flags;
    logic [7:0]  alu_Y;
    logic        alu_C_out;
    logic        alu_Z;
    logic        alu_N;
    logic        alu_V;

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  mflags;
    logic [15:0] last_y;
    logic [3:0]  last_rf;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_use_carry(req_use_carry),
        .req_set_flags(req_set_flags), .req_wide(req_wide),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .flags(flags), .flag_we(flag_we),
        .flag_wdata(flag_wdata), .busy(busy),
        .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP), .alu_C_in(alu_C_in),
        .alu_EN(alu_EN), .alu_update_flags(alu_update_flags),
        .alu_Y(alu_Y), .alu_C_out(alu_C_out), .alu_Z(alu_Z), .alu_N(alu_N),
        .alu_V(alu_V)
    );

    // Combinational alu_8 stand-in: shifts move by one bit; logic/shift return V=C=0.
    logic [8:0] alu_s;
    always_comb begin
        alu_s     = '0;
        alu_Y     = '0;
        alu_C_out = 1'b0;
        alu_V     = 1'b0;
        case (alu_OP)
            3'd0: begin
                alu_s     = {1'b0, alu_A} + {1'b0, alu_B} + {8'd0, alu_C_in};
                alu_Y     = alu_s[7:0];
                alu_C_out = alu_s[8];
                alu_V     = (alu_A[7] == alu_B[7]) && (alu_Y[7] != alu_A[7]);
            end
            3'd1: begin
                alu_s     = {1'b0, alu_A} + {1'b0, ~alu_B} + {8'd0, alu_C_in};
                alu_Y     = alu_s[7:0];
                alu_C_out = alu_s[8];
                alu_V     = (alu_A[7] != alu_B[7]) && (alu_Y[7] != alu_A[7]);
            end
            3'd2: alu_Y = alu_A & alu_B;
            3'd3: alu_Y = alu_A | alu_B;
            3'd4: alu_Y = alu_A ^ alu_B;
            3'd5: alu_Y = ~alu_A;
            3'd6: alu_Y = alu_A << 1;
            default: alu_Y = alu_A >> 1;
        endcase
        alu_Z = (alu_Y == 8'd0);
        alu_N = alu_Y[7];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operand arithmetic at 8 or 16 bits.
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  input logic uc, input logic wd, input logic cflag,
                                  output logic [15:0] y, output logic [3:0] f, output bit wide_eff);
        int unsigned w, mask, aa, bb, r, cin, yy;
        logic        v, c, sa, sb, sy;
        wide_eff = WIDE_EN && wd && (op <= 3'd5);
        w    = wide_eff ? 16 : 8;
        mask = (32'd1 << w) - 1;
        aa   = 32'(a) & mask;
        bb   = 32'(b) & mask;
        cin  = uc ? 32'(cflag) : ((op == 3'd1) ? 1 : 0);
        r    = 0;
        v    = 1'b0;
        c    = 1'b0;
        case (op)
            3'd0: r = aa + bb + cin;
            3'd1: r = aa + ((~bb) & mask) + cin;
            3'd2: r = aa & bb;
            3'd3: r = aa | bb;
            3'd4: r = aa ^ bb;
            3'd5: r = (~aa) & mask;
            3'd6: r = (aa << 1) & mask;
            default: r = aa >> 1;
        endcase
        yy = r & mask;
        sa = ((aa >> (w - 1)) & 1) != 0;
        sb = ((bb >> (w - 1)) & 1) != 0;
        sy = ((yy >> (w - 1)) & 1) != 0;
        if (op == 3'd0) begin
            c = ((r >> w) & 1) != 0;
            v = (sa == sb) && (sy != sa);
        end else if (op == 3'd1) begin
            c = ((r >> w) & 1) != 0;
            v = (sa != sb) && (sy != sa);
        end
        y = 16'(yy);
        f = {sy, (yy == 0), v, c};
    endfunction

    task automatic flag_write(input logic [3:0] d);
        @(negedge clk);
        flag_we    = 1'b1;
        flag_wdata = d;
        @(posedge clk);
        #1 flag_we = 1'b0;
        mflags = d;
        @(negedge clk);
        check("flag_we load", 32'(flags), 32'(d));
    endtask

    // One full transaction; fwe asserts flag_we only for the commit edge.
    task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic uc, input logic sf, input logic wd, input int stall,
                         input logic fwe, input logic [3:0] fwd);
        logic [15:0] ey;
        logic [3:0]  ef;
        bit          we;
        int          nexec;
        model(op, a, b, uc, wd, mflags[0], ey, ef, we);
        nexec = we ? 2 : 1;
        @(negedge clk);
        check("req_ready idle", 32'(req_ready), 1);
        check("alu_EN idle", 32'({alu_EN, alu_update_flags, alu_A, alu_B, alu_OP, alu_C_in}), 0);
        req_valid     = 1'b1;
        req_op        = op;
        req_a         = a;
        req_b         = b;
        req_use_carry = uc;
        req_set_flags = sf;
        req_wide      = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_op    = 3'($urandom);
        for (int k = 1; k <= nexec; k++) begin
            @(negedge clk);
            check("busy exec", 32'(busy), 1);
            check("rsp_valid exec", 32'(rsp_valid), 0);
            check("req_ready exec", 32'(req_ready), 0);
            check("alu_EN exec", 32'({alu_EN, alu_update_flags, alu_OP}), 32'({2'b11, op}));
            if ((k == nexec) && fwe) begin
                flag_we    = 1'b1;
                flag_wdata = fwd;
            end
        end
        @(posedge clk);
        #1 flag_we = 1'b0;
        if (sf) mflags = ef;
        else if (fwe) mflags = fwd;
        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            check("rsp_valid resp", 32'(rsp_valid), 1);
            check("rsp_y", 32'(rsp_y), 32'(ey));
            check("rsp_flags", 32'(rsp_flags), 32'(ef));
            check("flags commit", 32'(flags), 32'(mflags));
            check("req_ready resp", 32'(req_ready), 0);
            last_y  = rsp_y;
            last_rf = rsp_flags;
            if (s == stall) rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("req_ready after", 32'(req_ready), 1);
        check("rsp_valid after", 32'(rsp_valid), 0);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_use_carry = 1'b0; req_set_flags = 1'b0; req_wide = 1'b0;
        rsp_ready = 1'b0; flag_we = 1'b0; flag_wdata = '0;
        mflags = '0; last_y = '0; last_rf = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 0);
        check("reset rsp_valid", 32'(rsp_valid), 0);
        check("reset flags", 32'(flags), 0);
        check("reset busy", 32'(busy), 0);
        check("reset rsp_y", 32'(rsp_y), 0);
        rst = 1'b0;

        // ADD overflow into sign bit
        do_op(3'd0, 16'h007F, 16'h0001, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'h0);
        check("t1 y", 32'(last_y), 32'h0080);
        check("t1 flags", 32'(flags), 32'b1010);

        // SUB to zero, then SBC using C
        do_op(3'd1, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 0, 1'b0, 4'h0);
        check("t2 y", 32'(last_y), 32'h0000);
        check("t2 flags", 32'(flags), 32'b0101);
        do_op(3'd1, 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b0, 0, 1'b0, 4'h0);
        check("t2 sbc y", 32'(last_y), 32'h000F);

        // AND without flag commit
        flag_write(4'b1001);
        do_op(3'd2, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'h0);
        check("t3 rsp_flags", 32'(last_rf), 32'b0100);
        check("t3 flags", 32'(flags), 32'b1001);

        // Back-pressure on the response
        do_op(3'd3, 16'h00A5, 16'h005A, 1'b0, 1'b1, 1'b0, 3, 1'b0, 4'h0);
        check("t4 y", 32'(last_y), 32'h00FF);

        // Wide ADD carry across halves
        do_op(3'd0, 16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'h0);
        check("t5 y", 32'(last_y), WIDE_EN ? 32'h0100 : 32'h0000);
        check("t5 flags", 32'(flags), WIDE_EN ? 32'b0000 : 32'b0101);

        // Shifts, NOT and flag_we collisions
        do_op(3'd5, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4'b0011);
        check("not commit wins", 32'(flags), 32'b1000);
        do_op(3'd6, 16'h0081, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 1'b1, 4'b0110);
        check("flag_we no commit", 32'(flags), 32'b0110);
        do_op(3'd7, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'h0);
        check("lsr zero", 32'(flags), 32'b0100);

        // Reset in the middle of an operation
        flag_write(4'b1111);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0001; req_b = 16'h0001;
        req_set_flags = 1'b1; req_wide = 1'b0; req_use_carry = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("t6 exec busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6 busy", 32'(busy), 0);
        check("t6 flags", 32'(flags), 0);
        check("t6 rsp_valid", 32'(rsp_valid), 0);
        check("t6 req_ready in rst", 32'(req_ready), 0);
        rst = 1'b0;
        mflags = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6 no rsp", 32'(rsp_valid), 0);
        end
        check("t6 req_ready", 32'(req_ready), 1);

        // Random traffic against the reference
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0), 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
